// File: rtl/serv_decode_queue.sv
// Decode-and-buffer stage: each accepted ibus word is decoded into a compact
// control record and queued in a DEPTH-entry FIFO drained via valid/ready.
module serv_decode_queue #(
    parameter int DEPTH = 4,
    parameter int MDU   = 0,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_wb_rdt,
    input  logic             i_wb_en,
    output logic             o_wb_rdy,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [4:0]       o_opcode,
    output logic [2:0]       o_funct3,
    output logic [4:0]       o_rd,
    output logic [4:0]       o_rs1,
    output logic [4:0]       o_rs2,
    output logic             o_branch_op,
    output logic             o_mem_op,
    output logic             o_csr_op,
    output logic             o_mdu_op,
    output logic             o_e_op,
    output logic             o_ebreak,
    output logic             o_mret,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_count,
    output logic [7:0]       o_illegal_cnt
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       branch_op;
        logic       mem_op;
        logic       csr_op;
        logic       mdu_op;
        logic       e_op;
        logic       ebreak;
        logic       mret;
        logic       illegal;
    } rec_t;

    rec_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_illegal_cnt;

    rec_t             w_dec;
    rec_t             w_head;
    logic             w_legal;
    logic             w_push;
    logic             w_pop;
    logic [6:0]       w_funct7;

    assign w_funct7 = i_wb_rdt[31:25];

    always_comb begin
        w_dec        = '0;
        w_legal      = 1'b0;
        w_dec.opcode = i_wb_rdt[6:2];
        w_dec.funct3 = i_wb_rdt[14:12];
        w_dec.rd     = i_wb_rdt[11:7];
        w_dec.rs1    = i_wb_rdt[19:15];
        w_dec.rs2    = i_wb_rdt[24:20];
        if (i_wb_rdt[1:0] == 2'b11) begin
            case (i_wb_rdt[6:2])
                5'b00000, 5'b01000: begin
                    w_legal      = 1'b1;
                    w_dec.mem_op = 1'b1;
                end
                5'b00011, 5'b00100, 5'b00101, 5'b01101: w_legal = 1'b1;
                5'b11000, 5'b11001, 5'b11011: begin
                    w_legal         = 1'b1;
                    w_dec.branch_op = 1'b1;
                end
                5'b01100: begin
                    case (w_funct7)
                        7'b0000000: w_legal = 1'b1;
                        7'b0100000: w_legal = (i_wb_rdt[14:12] == 3'b000) ||
                                              (i_wb_rdt[14:12] == 3'b101);
                        7'b0000001: begin
                            w_legal      = (MDU != 0);
                            w_dec.mdu_op = (MDU != 0);
                        end
                        default: w_legal = 1'b0;
                    endcase
                end
                5'b11100: begin
                    if (i_wb_rdt[14:12] != 3'b000) begin
                        w_legal      = 1'b1;
                        w_dec.csr_op = 1'b1;
                    end else begin
                        // instr[31:7] of ECALL, EBREAK and MRET respectively
                        case (i_wb_rdt[31:7])
                            25'h0000000: begin
                                w_legal    = 1'b1;
                                w_dec.e_op = 1'b1;
                            end
                            25'h0002000: begin
                                w_legal      = 1'b1;
                                w_dec.e_op   = 1'b1;
                                w_dec.ebreak = 1'b1;
                            end
                            25'h0604000: begin
                                w_legal    = 1'b1;
                                w_dec.mret = 1'b1;
                            end
                            default: w_legal = 1'b0;
                        endcase
                    end
                end
                default: w_legal = 1'b0;
            endcase
        end
        if (!w_legal) begin
            w_dec.branch_op = 1'b0;
            w_dec.mem_op    = 1'b0;
            w_dec.csr_op    = 1'b0;
            w_dec.mdu_op    = 1'b0;
            w_dec.e_op      = 1'b0;
            w_dec.ebreak    = 1'b0;
            w_dec.mret      = 1'b0;
            w_dec.illegal   = 1'b1;
        end
    end

    assign o_wb_rdy = (r_count != CNT_W'(DEPTH));
    assign o_valid  = (r_count != '0);
    assign w_push   = i_wb_en & o_wb_rdy;
    assign w_pop    = o_valid & i_ready;

    // Storage needs no reset: payload is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push && !i_flush) begin
            r_mem[r_wptr] <= w_dec;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_illegal_cnt <= '0;
        end else begin
            if (w_push && !i_flush && w_dec.illegal && r_illegal_cnt != 8'hFF) begin
                r_illegal_cnt <= r_illegal_cnt + 8'd1;
            end
            if (i_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_W'(1);
                if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign w_head        = o_valid ? r_mem[r_rptr] : '0;
    assign o_opcode      = w_head.opcode;
    assign o_funct3      = w_head.funct3;
    assign o_rd          = w_head.rd;
    assign o_rs1         = w_head.rs1;
    assign o_rs2         = w_head.rs2;
    assign o_branch_op   = w_head.branch_op;
    assign o_mem_op      = w_head.mem_op;
    assign o_csr_op      = w_head.csr_op;
    assign o_mdu_op      = w_head.mdu_op;
    assign o_e_op        = w_head.e_op;
    assign o_ebreak      = w_head.ebreak;
    assign o_mret        = w_head.mret;
    assign o_illegal     = w_head.illegal;
    assign o_count       = r_count;
    assign o_illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_serv_decode_queue.sv
// Directed bench for serv_decode_queue: decode table plus queue corner cases,
// run on an MDU=0 and an MDU=1 instance sharing the same stimulus.
module tb_serv_decode_queue;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_wb_rdt;
    logic        i_wb_en;
    logic        i_flush;
    logic        i_ready;

    logic       rdy0, val0, br0, mem0, csr0, mdu0, e0, eb0, mret0, ill0;
    logic [4:0] op0, rd0, rs10, rs20;
    logic [2:0] f30;
    logic [2:0] cnt0;
    logic [7:0] icnt0;

    logic       rdy1, val1, br1, mem1, csr1, mdu1, e1, eb1, mret1, ill1;
    logic [4:0] op1, rd1, rs11, rs21;
    logic [2:0] f31;
    logic [2:0] cnt1;
    logic [7:0] icnt1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serv_decode_queue #(.DEPTH(4), .MDU(0)) u_dut0 (
        .clk(clk), .i_rst_n(i_rst_n), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
        .o_wb_rdy(rdy0), .i_flush(i_flush), .o_valid(val0), .i_ready(i_ready),
        .o_opcode(op0), .o_funct3(f30), .o_rd(rd0), .o_rs1(rs10), .o_rs2(rs20),
        .o_branch_op(br0), .o_mem_op(mem0), .o_csr_op(csr0), .o_mdu_op(mdu0),
        .o_e_op(e0), .o_ebreak(eb0), .o_mret(mret0), .o_illegal(ill0),
        .o_count(cnt0), .o_illegal_cnt(icnt0)
    );

    serv_decode_queue #(.DEPTH(4), .MDU(1)) u_dut1 (
        .clk(clk), .i_rst_n(i_rst_n), .i_wb_rdt(i_wb_rdt), .i_wb_en(i_wb_en),
        .o_wb_rdy(rdy1), .i_flush(i_flush), .o_valid(val1), .i_ready(i_ready),
        .o_opcode(op1), .o_funct3(f31), .o_rd(rd1), .o_rs1(rs11), .o_rs2(rs21),
        .o_branch_op(br1), .o_mem_op(mem1), .o_csr_op(csr1), .o_mdu_op(mdu1),
        .o_e_op(e1), .o_ebreak(eb1), .o_mret(mret1), .o_illegal(ill1),
        .o_count(cnt1), .o_illegal_cnt(icnt1)
    );

    // flag order: branch, mem, csr, mdu, e, ebreak, mret, illegal
    wire [7:0] fl0 = {br0, mem0, csr0, mdu0, e0, eb0, mret0, ill0};
    wire [7:0] fl1 = {br1, mem1, csr1, mdu1, e1, eb1, mret1, ill1};

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  opcode;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [7:0]  fl_m0;
        logic [7:0]  fl_m1;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        i_wb_en  = 1'b1;
        i_wb_rdt = w;
        tick();
        i_wb_en  = 1'b0;
    endtask

    task automatic pop();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    function automatic logic [31:0] addi_rd(input int unsigned k);
        return 32'h00000013 | (k << 7);
    endfunction

    int exp_icnt0 = 0;
    int exp_icnt1 = 0;

    initial begin
        vecs[0]  = '{32'h12300093, 5'b00100, 3'd0, 5'd1,  8'h00, 8'h00};
        vecs[1]  = '{32'h00000063, 5'b11000, 3'd0, 5'd0,  8'h80, 8'h80};
        vecs[2]  = '{32'h30200073, 5'b11100, 3'd0, 5'd0,  8'h02, 8'h02};
        vecs[3]  = '{32'h00100073, 5'b11100, 3'd0, 5'd0,  8'h0C, 8'h0C};
        vecs[4]  = '{32'h00000073, 5'b11100, 3'd0, 5'd0,  8'h08, 8'h08};
        vecs[5]  = '{32'h022081B3, 5'b01100, 3'd0, 5'd3,  8'h01, 8'h10};
        vecs[6]  = '{32'h40000033, 5'b01100, 3'd0, 5'd0,  8'h00, 8'h00};
        vecs[7]  = '{32'h40001033, 5'b01100, 3'd1, 5'd0,  8'h01, 8'h01};
        vecs[8]  = '{32'h00000000, 5'b00000, 3'd0, 5'd0,  8'h01, 8'h01};
        vecs[9]  = '{32'h0000007F, 5'b11111, 3'd0, 5'd0,  8'h01, 8'h01};
        vecs[10] = '{32'h00003023, 5'b01000, 3'd3, 5'd0,  8'h40, 8'h40};
        vecs[11] = '{32'h10000073, 5'b11100, 3'd0, 5'd0,  8'h01, 8'h01};
        vecs[12] = '{32'h30002573, 5'b11100, 3'd2, 5'd10, 8'h20, 8'h20};
        vecs[13] = '{32'h0000006F, 5'b11011, 3'd0, 5'd0,  8'h80, 8'h80};
        vecs[14] = '{32'h00000067, 5'b11001, 3'd0, 5'd0,  8'h80, 8'h80};

        i_rst_n = 1'b0; i_wb_rdt = '0; i_wb_en = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
        tick(); tick();
        chk("rst_valid", 32'(val0), 32'd0);
        chk("rst_rdy",   32'(rdy0), 32'd1);
        chk("rst_count", 32'(cnt0), 32'd0);
        chk("rst_icnt",  32'(icnt0), 32'd0);
        chk("rst_payload", {op0, f30, rd0, rs10, rs20, fl0}, 32'd0);
        i_rst_n = 1'b1;
        tick();

        // Decode table: each word goes through an empty queue.
        for (int i = 0; i < 15; i++) begin
            push(vecs[i].instr);
            chk($sformatf("v%0d_valid", i), 32'(val0), 32'd1);
            chk($sformatf("v%0d_count", i), 32'(cnt0), 32'd1);
            chk($sformatf("v%0d_opcode", i), 32'(op0), 32'(vecs[i].opcode));
            chk($sformatf("v%0d_funct3", i), 32'(f30), 32'(vecs[i].f3));
            chk($sformatf("v%0d_rd", i), 32'(rd0), 32'(vecs[i].rd));
            chk($sformatf("v%0d_flags_m0", i), 32'(fl0), 32'(vecs[i].fl_m0));
            chk($sformatf("v%0d_flags_m1", i), 32'(fl1), 32'(vecs[i].fl_m1));
            exp_icnt0 += int'(vecs[i].fl_m0[0]);
            exp_icnt1 += int'(vecs[i].fl_m1[0]);
            if (i == 5) begin
                chk("mul_rs1", 32'(rs11), 32'd1);
                chk("mul_rs2", 32'(rs21), 32'd2);
                chk("mul_rd_m1", 32'(rd1), 32'd3);
            end
            pop();
            chk($sformatf("v%0d_empty", i), 32'(val0), 32'd0);
        end
        chk("icnt_m0", 32'(icnt0), 32'(exp_icnt0));
        chk("icnt_m1", 32'(icnt1), 32'(exp_icnt1));

        // Three queued entries drain in order.
        push(32'h00000063);
        push(32'h30200073);
        push(32'h00100073);
        chk("q3_count", 32'(cnt0), 32'd3);
        chk("q3_head_branch", 32'(fl0), 32'h80);
        pop();
        chk("q3_head_mret", 32'(fl0), 32'h02);
        pop();
        chk("q3_head_ebreak", 32'(fl0), 32'h0C);
        pop();
        chk("q3_drained", 32'(val0), 32'd0);

        // Fill to DEPTH, fifth word dropped, push+pop while full pops only.
        i_wb_en = 1'b1;
        for (int unsigned k = 1; k <= 5; k++) begin
            i_wb_rdt = addi_rd(k);
            tick();
            if (k == 4) chk("full_rdy_after4", 32'(rdy0), 32'd0);
        end
        chk("full_count", 32'(cnt0), 32'd4);
        i_wb_rdt = addi_rd(6);
        i_ready  = 1'b1;
        tick();
        i_wb_en = 1'b0;
        i_ready = 1'b0;
        chk("full_pushpop_count", 32'(cnt0), 32'd3);
        chk("full_pushpop_rdy", 32'(rdy0), 32'd1);
        for (int unsigned k = 2; k <= 4; k++) begin
            chk($sformatf("full_drain_rd%0d", k), 32'(rd0), 32'(k));
            pop();
        end
        chk("full_drain_empty", 32'(val0), 32'd0);

        // Flush beats a simultaneous push and pop.
        push(addi_rd(7));
        push(addi_rd(8));
        push(addi_rd(9));
        i_flush = 1'b1; i_wb_en = 1'b1; i_ready = 1'b1; i_wb_rdt = addi_rd(10);
        tick();
        i_flush = 1'b0; i_wb_en = 1'b0; i_ready = 1'b0;
        chk("flush_count", 32'(cnt0), 32'd0);
        chk("flush_valid", 32'(val0), 32'd0);
        tick();
        chk("flush_stays_empty", 32'(cnt0), 32'd0);
        push(addi_rd(11));
        chk("flush_next_head_rd", 32'(rd0), 32'd11);
        chk("flush_next_count", 32'(cnt0), 32'd1);
        pop();

        // Illegal counter saturates.
        i_ready = 1'b1; i_wb_en = 1'b1; i_wb_rdt = 32'h00000000;
        for (int n = 0; n < 260; n++) tick();
        i_wb_en = 1'b0;
        tick();
        i_ready = 1'b0;
        chk("sat_icnt_m0", 32'(icnt0), 32'd255);
        chk("sat_icnt_m1", 32'(icnt1), 32'd255);
        chk("sat_empty", 32'(val0), 32'd0);

        // Asynchronous reset with data queued.
        push(addi_rd(12));
        push(addi_rd(13));
        chk("pre_rst_count", 32'(cnt0), 32'd2);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(val0), 32'd0);
        chk("arst_count", 32'(cnt0), 32'd0);
        chk("arst_icnt", 32'(icnt0), 32'd0);
        chk("arst_rdy", 32'(rdy0), 32'd1);
        chk("arst_payload", {op0, f30, rd0, rs10, rs20, fl0}, 32'd0);
        tick();
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        tick(); tick();
        i_ready = 1'b0;
        chk("post_rst_valid", 32'(val0), 32'd0);
        chk("post_rst_count", 32'(cnt0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
